coin_start_sequencer: RTL and testbench

COIN_START_SEQUENCER -- requirements
Module: coin_start_sequencer

---
 rtl/coin_seq_pkg.sv | 36 +++
 rtl/btn_debounce.sv | 66 ++++++
 rtl/coin_start_sequencer.sv | 148 ++++++++++++++
 tb/tb_coin_start_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : coin_seq_pkg
//  Purpose  : Shared state encoding, default timing constants and the
//             saturating credit-add helper for the coin/start sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package coin_seq_pkg;

    // Default timing / credit constants (in tick_1ms periods where timed)
    localparam int unsigned c_DEB_MS      = 8;
    localparam int unsigned c_PULSE_MS    = 50;
    localparam int unsigned c_GAP_MS      = 50;
    localparam int unsigned c_MAX_CREDITS = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COIN  = 2'd1,
        ST_START = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

    // Add one or two credits, clamping at max_val so the counter never wraps
    function automatic logic [3:0] sat_add(input logic [3:0]  cur,
                                           input logic        two,
                                           input int unsigned max_val);
        logic [4:0] sum;
        sum = {1'b0, cur} + (two ? 5'd2 : 5'd1);
        if (32'(sum) > max_val) begin
            return 4'(max_val);
        end
        return sum[3:0];
    endfunction

endpackage : coin_seq_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : btn_debounce
//  Purpose  : 2-flop synchronizer, tick-based debounce and a one-cycle pulse
//             on every debounced 0->1 transition of a raw button.
//  Revision : 1.0  initial release
// ============================================================================
module btn_debounce
    import coin_seq_pkg::*;
#(
    parameter int unsigned DEB_MS = c_DEB_MS
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_press
);

    // Counter runs 0..DEB_MS-1; the DEB_MS-th differing tick commits the level
    localparam int unsigned CNT_W = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEB_MS - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Bring the asynchronous button into the clk_sys domain
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has differed for DEB_MS ticks in a row
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (i_tick) begin
                if (r_cnt == c_LAST) begin
                    r_stable <= r_sync2;
                    r_cnt    <= '0;
                    r_press  <= r_sync2;   // only rising commits produce a press
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/coin_start_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : coin_start_sequencer
//  Purpose  : Debounces coin/start buttons, keeps a saturating credit count
//             and emits clean, spaced coin/start pulses to the game core.
//  Revision : 1.0  initial release
// ============================================================================
module coin_start_sequencer
    import coin_seq_pkg::*;
#(
    parameter int unsigned DEB_MS      = c_DEB_MS,
    parameter int unsigned PULSE_MS    = c_PULSE_MS,
    parameter int unsigned GAP_MS      = c_GAP_MS,
    parameter int unsigned MAX_CREDITS = c_MAX_CREDITS
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic       tick_1ms,
    input  logic       coin_in,
    input  logic       start_in,
    input  logic       two_per_coin,
    output logic       coin_out,
    output logic       start_out,
    output logic [3:0] credits,
    output logic       busy
);

    localparam int unsigned TMAX  = (PULSE_MS > GAP_MS) ? PULSE_MS : GAP_MS;
    localparam int unsigned CNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [CNT_W-1:0] c_PULSE_LAST = CNT_W'(PULSE_MS - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST   = CNT_W'(GAP_MS - 1);

    logic             w_coin_press;
    logic             w_start_press;

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_credits;
    logic             r_coin_pend;
    logic             r_start_pend;
    logic             r_coin_out;
    logic             r_start_out;
    logic             r_busy;

    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [3:0]       w_credits_nxt;
    logic             w_coin_pend_nxt;
    logic             w_start_pend_nxt;

    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_coin (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_tick  (tick_1ms),
        .i_raw   (coin_in),
        .o_press (w_coin_press)
    );

    btn_debounce #(.DEB_MS(DEB_MS)) u_deb_start (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .i_tick  (tick_1ms),
        .i_raw   (start_in),
        .o_press (w_start_press)
    );

    // Next-state, tick counter, credit and pending-flag logic
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_credits_nxt = r_credits;
        // A press while the flag is already set is simply absorbed by the OR
        w_coin_pend_nxt  = r_coin_pend  | w_coin_press;
        w_start_pend_nxt = r_start_pend | w_start_press;

        case (r_state)
            ST_IDLE: begin
                // Coin has priority; a simultaneous start waits until after GAP
                if (r_coin_pend) begin
                    w_state_nxt     = ST_COIN;
                    w_coin_pend_nxt = 1'b0;
                    w_credits_nxt   = sat_add(r_credits, two_per_coin, MAX_CREDITS);
                end else if (r_start_pend) begin
                    w_start_pend_nxt = 1'b0;
                    if (r_credits != 4'd0) begin
                        w_state_nxt   = ST_START;
                        w_credits_nxt = r_credits - 4'd1;
                    end
                end
            end
            ST_COIN, ST_START: begin
                if (tick_1ms) begin
                    if (r_cnt == c_PULSE_LAST) begin
                        w_state_nxt = ST_GAP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tick_1ms) begin
                    if (r_cnt == c_GAP_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end
    end

    // State register plus registered outputs decoded from the next state
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_credits    <= 4'd0;
            r_coin_pend  <= 1'b0;
            r_start_pend <= 1'b0;
            r_coin_out   <= 1'b0;
            r_start_out  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_credits    <= w_credits_nxt;
            r_coin_pend  <= w_coin_pend_nxt;
            r_start_pend <= w_start_pend_nxt;
            r_coin_out   <= (w_state_nxt == ST_COIN);
            r_start_out  <= (w_state_nxt == ST_START);
            r_busy       <= (w_state_nxt != ST_IDLE);
        end
    end

    assign coin_out  = r_coin_out;
    assign start_out = r_start_out;
    assign credits   = r_credits;
    assign busy      = r_busy;

endmodule : coin_start_sequencer
`default_nettype wire

// File: tb/tb_coin_start_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_coin_start_sequencer
//  Purpose  : Directed self-checking bench with a pulse scoreboard for the
//             coin/start sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_coin_start_sequencer;

    localparam int DEB_MS      = 8;
    localparam int PULSE_MS    = 50;
    localparam int GAP_MS      = 50;
    localparam int MAX_CREDITS = 9;
    localparam int TICK_DIV    = 4;   // clk_sys cycles per tick_1ms

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_1ms = 1'b0;
    logic       coin_in = 1'b0;
    logic       start_in = 1'b0;
    logic       two_per_coin = 1'b0;
    logic       coin_out;
    logic       start_out;
    logic [3:0] credits;
    logic       busy;

    typedef struct {
        int kind;    // 1 = coin pulse, 2 = start pulse
        int cred;    // credits visible while the pulse is high
    } exp_t;

    exp_t q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   n_pulses = 0;
    int   n_busy   = 0;
    int   m_cred   = 0;

    coin_start_sequencer #(
        .DEB_MS      (DEB_MS),
        .PULSE_MS    (PULSE_MS),
        .GAP_MS      (GAP_MS),
        .MAX_CREDITS (MAX_CREDITS)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .tick_1ms     (tick_1ms),
        .coin_in      (coin_in),
        .start_in     (start_in),
        .two_per_coin (two_per_coin),
        .coin_out     (coin_out),
        .start_out    (start_out),
        .credits      (credits),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // One-cycle tick every TICK_DIV clocks
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge clk_sys);
            #1 tick_1ms = ((cyc % TICK_DIV) == (TICK_DIV - 1));
            cyc++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Scoreboard monitor: measures each pulse and each busy episode
    initial begin
        int cur;
        int p_kind;
        int p_ticks;
        int p_cred;
        bit b_in;
        int b_ticks;
        exp_t e;
        p_kind = 0; p_ticks = 0; p_cred = 0; b_in = 1'b0; b_ticks = 0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                p_kind = 0;
                b_in   = 1'b0;
            end else begin
                if (coin_out && start_out) chk("both_high", 1, 0);
                cur = coin_out ? 1 : (start_out ? 2 : 0);
                if (p_kind != 0 && cur != p_kind) begin
                    n_pulses++;
                    if (q.size() == 0) begin
                        chk("unexpected_pulse", p_kind, 0);
                    end else begin
                        e = q.pop_front();
                        chk("pulse_kind", p_kind, e.kind);
                        chk("pulse_ticks", p_ticks, PULSE_MS);
                        chk("pulse_credits", p_cred, e.cred);
                    end
                    p_kind = 0;
                end
                if (cur != 0 && p_kind == 0) begin
                    p_kind  = cur;
                    p_ticks = 0;
                    p_cred  = int'(credits);
                end
                if (p_kind != 0 && tick_1ms) p_ticks++;

                if (busy) begin
                    if (!b_in) begin
                        b_in    = 1'b1;
                        b_ticks = 0;
                    end
                    if (tick_1ms) b_ticks++;
                end else if (b_in) begin
                    b_in = 1'b0;
                    n_busy++;
                    chk("busy_ticks", b_ticks, PULSE_MS + GAP_MS);
                end
            end
        end
    end

    task automatic coin_exp(input bit two);
        m_cred = m_cred + (two ? 2 : 1);
        if (m_cred > MAX_CREDITS) m_cred = MAX_CREDITS;
        q.push_back('{kind: 1, cred: m_cred});
    endtask

    task automatic start_exp();
        if (m_cred > 0) begin
            m_cred = m_cred - 1;
            q.push_back('{kind: 2, cred: m_cred});
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic press(input bit c, input bit s, input int hold_ticks);
        @(posedge clk_sys);
        #1;
        coin_in  = c;
        start_in = s;
        wait_clks(hold_ticks * TICK_DIV);
        coin_in  = 1'b0;
        start_in = 1'b0;
    endtask

    // Wait until the scoreboard drains and the FSM is idle, then let buttons settle
    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 4000; k++) begin
            @(negedge clk_sys);
            if (q.size() == 0 && !busy) break;
        end
        chk(tag, int'(k < 4000), 1);
        wait_clks(40 * TICK_DIV);
    endtask

    initial begin
        int n;
        int k;
        int snap_p;
        int snap_b;

        // ---- reset state ----
        wait_clks(3);
        chk("rst_coin_out", int'(coin_out), 0);
        chk("rst_start_out", int'(start_out), 0);
        chk("rst_credits", int'(credits), 0);
        chk("rst_busy", int'(busy), 0);
        reset_n = 1'b1;
        wait_clks(8);

        // ---- single coin, measure debounce latency ----
        two_per_coin = 1'b0;
        coin_exp(1'b0);
        @(negedge clk_sys);
        while (!tick_1ms) @(negedge clk_sys);
        @(posedge clk_sys);
        #1 coin_in = 1'b1;
        n = 0;
        for (k = 0; k < 400; k++) begin
            @(negedge clk_sys);
            if (coin_out) break;
            if (tick_1ms) n++;
        end
        chk("deb_found", int'(k < 400), 1);
        chk("deb_ticks", n, DEB_MS);
        wait_clks((20 - DEB_MS) * TICK_DIV);
        coin_in = 1'b0;
        wait_done("coin1_done");
        chk("coin1_credits", int'(credits), m_cred);

        // ---- 5 ms glitch is rejected ----
        snap_p = n_pulses;
        press(1'b1, 1'b0, 5);
        wait_clks(40 * TICK_DIV);
        chk("glitch_pulses", n_pulses, snap_p);
        chk("glitch_credits", int'(credits), m_cred);

        // ---- start with one credit, then start with none ----
        start_exp();
        press(1'b0, 1'b1, 12);
        wait_done("start1_done");
        chk("start1_credits", int'(credits), 0);
        snap_p = n_pulses;
        snap_b = n_busy;
        press(1'b0, 1'b1, 12);
        wait_clks(60 * TICK_DIV);
        chk("start0_pulses", n_pulses, snap_p);
        chk("start0_busy", n_busy, snap_b);
        chk("start0_credits", int'(credits), 0);

        // ---- simultaneous coin and start, two per coin ----
        two_per_coin = 1'b1;
        coin_exp(1'b1);
        start_exp();
        press(1'b1, 1'b1, 12);
        wait_done("both_done");
        chk("both_credits", int'(credits), m_cred);

        // ---- climb to 8, then saturate at 9 ----
        for (int i = 0; i < 4; i++) begin
            two_per_coin = (i < 3);
            coin_exp(two_per_coin);
            press(1'b1, 1'b0, 12);
            wait_done("climb_done");
        end
        chk("climb_credits", int'(credits), 8);
        for (int i = 0; i < 2; i++) begin
            two_per_coin = 1'b1;
            coin_exp(1'b1);
            press(1'b1, 1'b0, 12);
            wait_done("sat_done");
            chk("sat_credits", int'(credits), MAX_CREDITS);
        end

        // ---- reset 10 ticks into a coin pulse ----
        two_per_coin = 1'b0;
        @(posedge clk_sys);
        #1 coin_in = 1'b1;
        for (k = 0; k < 400; k++) begin
            @(negedge clk_sys);
            if (coin_out) break;
        end
        chk("abort_pulse_seen", int'(k < 400), 1);
        coin_in = 1'b0;
        n = 0;
        for (k = 0; k < 400 && n < 10; k++) begin
            @(negedge clk_sys);
            if (tick_1ms) n++;
        end
        @(posedge clk_sys);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_coin_out", int'(coin_out), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_credits", int'(credits), 0);
        m_cred = 0;
        wait_clks(3);
        snap_p = n_pulses;
        snap_b = n_busy;
        reset_n = 1'b1;
        wait_clks(200 * TICK_DIV);
        chk("post_abort_pulses", n_pulses, snap_p);
        chk("post_abort_busy", n_busy, snap_b);
        chk("post_abort_credits", int'(credits), 0);

        // ---- button held through reset release registers once ----
        @(posedge clk_sys);
        #1 reset_n = 1'b0;
        coin_in = 1'b1;
        wait_clks(3);
        reset_n = 1'b1;
        coin_exp(1'b0);
        wait_clks(20 * TICK_DIV);
        coin_in = 1'b0;
        wait_done("held_done");
        chk("held_credits", int'(credits), 1);

        chk("queue_empty", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_coin_start_sequencer
`default_nettype wire
